keypad_scanner: RTL and testbench

//   Scans a 4x4 active-low matrix keypad, debounces presses and delivers hex key codes.

---
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad with a walking-zero column strobe,
//   debounces whole-keypad frames and delivers hex key codes. Accepted nibbles
//   shift into a 16-bit word (newest in [3:0]) that can feed a four-digit
//   seven-segment display directly.
//
// Parameters
//   SCAN_DIV_BITS   prescaler width; one column step per 2**SCAN_DIV_BITS clks
//   DEBOUNCE_SCANS  identical consecutive frames needed for press/release (>=2)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   rows [3:0] in   keypad rows, active-low, asynchronous
//   clr        in   one-cycle strobe clearing data
//   cols [3:0] out  column drive, active-low, exactly one zero
//   key_code   out  last accepted key, code = row*4 + col
//   key_valid  out  one-cycle pulse on a new accepted key
//   key_held   out  high while the accepted key has not been released
//   data       out  entered digits, newest nibble in [3:0]
module keypad_scanner #(
  parameter int SCAN_DIV_BITS  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  input  logic        clr,
  output logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] data
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]               rows_meta;
  logic [3:0]               rows_sync;
  logic [SCAN_DIV_BITS-1:0] cnt;
  logic [1:0]               col_idx;
  logic                     tick;
  logic                     frame_end;

  // Per-frame accumulation: hit count saturates at 2 (0 = none, 1 = single, 2 = multi)
  logic [1:0]               hit_acc;
  logic [3:0]               code_acc;
  logic [2:0]               col_hits;
  logic [1:0]               col_row;
  logic [1:0]               hit_sum;
  logic [3:0]               code_sum;

  state_t                   state, state_next;
  logic [3:0]               cand, cand_next;
  logic [CW-1:0]            n_cnt, n_next;
  logic [CW-1:0]            rel_cnt, rel_next;
  logic                     accept;

  assign tick      = &cnt;
  assign frame_end = tick && (col_idx == 2'd3);
  assign cols      = ~(4'b0001 << col_idx);
  assign key_held  = (state == HELD);

  // Two-flop synchronizer, prescaler and column rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
      cnt       <= '0;
      col_idx   <= 2'd0;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
      cnt       <= cnt + 1'b1;
      if (tick) begin
        col_idx <= col_idx + 2'd1;
      end
    end
  end

  // Pressed rows in the currently driven column; scanning downwards leaves the lowest row
  always_comb begin
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
  end

  // Merge this column into the frame; the first hit found (lowest column) keeps its code
  always_comb begin
    hit_sum  = hit_acc;
    code_sum = code_acc;
    if (col_hits != 3'd0) begin
      if (hit_acc == 2'd0) begin
        code_sum = {col_row, col_idx};
        hit_sum  = (col_hits == 3'd1) ? 2'd1 : 2'd2;
      end else begin
        hit_sum  = 2'd2;
      end
    end
  end

  // Frame accumulator, cleared after the column-3 sample closes the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_acc  <= 2'd0;
      code_acc <= 4'd0;
    end else if (tick) begin
      if (frame_end) begin
        hit_acc  <= 2'd0;
        code_acc <= 4'd0;
      end else begin
        hit_acc  <= hit_sum;
        code_acc <= code_sum;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= 4'd0;
      n_cnt   <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_next;
      cand    <= cand_next;
      n_cnt   <= n_next;
      rel_cnt <= rel_next;
    end
  end

  // FSM next state; decisions are made only on the frame-closing tick
  always_comb begin
    state_next = state;
    cand_next  = cand;
    n_next     = n_cnt;
    rel_next   = rel_cnt;
    accept     = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (hit_sum == 2'd1) begin
            state_next = DEBOUNCE;
            cand_next  = code_sum;
            n_next     = CW'(1);
          end
        end
        DEBOUNCE: begin
          if (hit_sum == 2'd1 && code_sum == cand) begin
            if (n_cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
              state_next = HELD;
              n_next     = '0;
              rel_next   = '0;
              accept     = 1'b1;
            end else begin
              n_next = n_cnt + CW'(1);
            end
          end else begin
            // A changed, missing or ambiguous frame abandons the candidate outright
            state_next = IDLE;
            n_next     = '0;
          end
        end
        HELD: begin
          if (hit_sum == 2'd0) begin
            if (rel_cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
              state_next = IDLE;
              rel_next   = '0;
            end else begin
              rel_next = rel_cnt + CW'(1);
            end
          end else begin
            // Any key activity while held restarts the release count
            rel_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Output registers; a clear coinciding with an acceptance keeps only the new digit
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      data      <= 16'h0000;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand;
      end
      if (clr) begin
        data <= accept ? {12'h000, cand} : 16'h0000;
      end else if (accept) begin
        data <= {data[11:0], cand};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner with a 4-clock tick and 3-frame
//   debounce. A keypad model turns a 16-bit pressed-key set into row levels
//   from the driven columns. A frame-level model predicts the outputs, a
//   compare process checks every cycle, and directed scenarios pin literals.
module tb_keypad_scanner;

  localparam int DIV_BITS = 2;
  localparam int DS       = 3;
  localparam int FRAME    = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  rows;
  logic        clr;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] data;

  logic [15:0] keys;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_count = 0;
  int last_valid_cyc = -1;

  // Model state
  int          cyc = 0;
  bit          model_live = 0;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_held;
  logic [15:0] m_data;
  logic [3:0]  m_cand;
  int          streak;
  int          quiet;

  keypad_scanner #(
    .SCAN_DIV_BITS (DIV_BITS),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rows     (rows),
    .clr      (clr),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .data     (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a pressed key sits on a driven column
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      rows[r] = ~|(keys[r*4 +: 4] & ~cols);
    end
  end

  // Frame-level reference model, evaluated at each clock edge
  always @(posedge clk) begin
    int nk;
    int code;
    bit found;
    bit accept;
    if (rst) begin
      cyc        = 0;
      model_live = 1;
      m_valid    = 0;
      m_code     = 0;
      m_held     = 0;
      m_data     = 0;
      m_cand     = 0;
      streak     = 0;
      quiet      = 0;
    end else if (model_live) begin
      cyc++;
      m_valid = 0;
      accept  = 0;
      if (cyc % FRAME == 0) begin
        nk    = $countones(keys);
        code  = 0;
        found = 0;
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            if (!found && keys[r*4 + c]) begin
              found = 1;
              code  = r*4 + c;
            end
          end
        end
        if (m_held) begin
          if (nk == 0) begin
            quiet++;
            if (quiet == DS) m_held = 0;
          end else begin
            quiet = 0;
          end
        end else if (streak > 0) begin
          if (nk == 1 && code == int'(m_cand)) begin
            streak++;
            if (streak == DS) begin
              accept = 1;
              streak = 0;
              quiet  = 0;
              m_held = 1;
            end
          end else begin
            streak = 0;
          end
        end else if (nk == 1) begin
          m_cand = 4'(code);
          streak = 1;
        end
      end
      if (accept) begin
        m_valid = 1;
        m_code  = m_cand;
      end
      if (clr) m_data = accept ? {12'h000, m_cand} : 16'h0000;
      else if (accept) m_data = {m_data[11:0], m_cand};
    end
  end

  // Per-cycle comparison, taken 2 time units after the rising edge
  always @(posedge clk) begin
    logic [3:0] ec;
    #2;
    if (model_live) begin
      ec = 4'b1111 ^ (4'b0001 << ((cyc / 4) % 4));
      vectors++;
      if (cols !== ec) begin
        miscompares++;
        $display("[TB] FAIL cols cyc=%0d got %b expected %b", cyc, cols, ec);
      end
      if (key_valid !== m_valid) begin
        miscompares++;
        $display("[TB] FAIL key_valid cyc=%0d got %b expected %b", cyc, key_valid, m_valid);
      end
      if (key_code !== m_code) begin
        miscompares++;
        $display("[TB] FAIL key_code cyc=%0d got %h expected %h", cyc, key_code, m_code);
      end
      if (key_held !== m_held) begin
        miscompares++;
        $display("[TB] FAIL key_held cyc=%0d got %b expected %b", cyc, key_held, m_held);
      end
      if (data !== m_data) begin
        miscompares++;
        $display("[TB] FAIL data cyc=%0d got %h expected %h", cyc, data, m_data);
      end
      if (key_valid === 1'b1) begin
        pulse_count++;
        last_valid_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  // Hold a key set for n whole frames; returns just after the n-th frame closes
  task automatic applyStimulus(input logic [15:0] k, input int nframes);
    keys = k;
    repeat (nframes) begin
      do @(negedge clk); while (cyc % FRAME != 0);
    end
  endtask

  task automatic enterKey(input int code, input logic [15:0] exp_data);
    int base;
    base = pulse_count;
    applyStimulus(16'h0001 << code, DS);
    checkOutput("enter_pulse", 16'(pulse_count - base), 16'd1);
    checkOutput("enter_data", data, exp_data);
    applyStimulus(16'h0000, DS);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    rst  = 1'b1;
    clr  = 1'b0;
    keys = 16'h0000;

    // Reset values and column stepping
    repeat (3) @(negedge clk);
    checkOutput("rst_cols", {12'h000, cols}, 16'h000E);
    checkOutput("rst_data", data, 16'h0000);
    checkOutput("rst_valid", {15'h0, key_valid}, 16'h0000);
    checkOutput("rst_held", {15'h0, key_held}, 16'h0000);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("cols_step", {12'h000, cols}, 16'h000D);
    repeat (12) @(negedge clk);

    // Stable press of code 6 (row1/col2) for 5 frames, then release
    base = pulse_count;
    applyStimulus(16'h0040, 5);
    checkOutput("t1_pulses", 16'(pulse_count - base), 16'd1);
    checkOutput("t1_valid_cyc", 16'(last_valid_cyc), 16'd64);
    checkOutput("t1_code", {12'h000, key_code}, 16'h0006);
    checkOutput("t1_data", data, 16'h0006);
    checkOutput("t1_held", {15'h0, key_held}, 16'h0001);
    applyStimulus(16'h0000, 2);
    checkOutput("t1_held_2empty", {15'h0, key_held}, 16'h0001);
    applyStimulus(16'h0000, 1);
    checkOutput("t1_released", {15'h0, key_held}, 16'h0000);

    // Bounce: 2 frames, gap, 3 frames of code 9
    base = pulse_count;
    applyStimulus(16'h0200, 2);
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h0200, 2);
    checkOutput("t2_no_early", 16'(pulse_count - base), 16'd0);
    applyStimulus(16'h0200, 1);
    checkOutput("t2_pulses", 16'(pulse_count - base), 16'd1);
    checkOutput("t2_code", {12'h000, key_code}, 16'h0009);
    applyStimulus(16'h0000, DS);

    // Digit entry with clear
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(16'h0000, 1);
    checkOutput("t3_clr0", data, 16'h0000);
    enterKey(1, 16'h0001);
    enterKey(2, 16'h0012);
    enterKey(3, 16'h0123);
    enterKey(4, 16'h1234);
    enterKey(10, 16'h234A);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(16'h0000, 1);
    checkOutput("t3_clr", data, 16'h0000);
    applyStimulus(16'h0020, 2);
    while (cyc % FRAME != FRAME - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("t3_clr_accept", data, 16'h0005);
    checkOutput("t3_code5", {12'h000, key_code}, 16'h0005);
    applyStimulus(16'h0000, DS);

    // Two keys together, then release of key 15
    base = pulse_count;
    applyStimulus(16'h8001, 6);
    checkOutput("t4_multi", 16'(pulse_count - base), 16'd0);
    applyStimulus(16'h0001, DS);
    checkOutput("t4_pulses", 16'(pulse_count - base), 16'd1);
    checkOutput("t4_code", {12'h000, key_code}, 16'h0000);
    checkOutput("t4_data", data, 16'h0050);
    applyStimulus(16'h0000, DS);

    // Reset during debounce with the key still down
    base = pulse_count;
    applyStimulus(16'h0008, 2);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_no_pulse", 16'(pulse_count - base), 16'd0);
    checkOutput("t5_data_rst", data, 16'h0000);
    applyStimulus(16'h0008, DS);
    checkOutput("t5_pulses", 16'(pulse_count - base), 16'd1);
    checkOutput("t5_valid_cyc", 16'(last_valid_cyc), 16'd48);
    checkOutput("t5_code", {12'h000, key_code}, 16'h0003);
    checkOutput("t5_data", data, 16'h0003);
    applyStimulus(16'h0000, DS);
    checkOutput("t5_released", {15'h0, key_held}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
